boa_mem_initiator: RTL and testbench

// - Single-outstanding bus master on boa_mem_bus; the requesting end of the protocol served by MMIO responders (timer, GPIO, RAM).
// - Converts valid/ready command stream (debug bridge, DMA, bench driver) into one bus access; returns read data/status on a response stream.
// - Handles wait-state responders that drop ready and stall, with optional timeout recovery.

---
 rtl/boa_mem_initiator.sv | 155 +++++++++++++++
 tb/tb_boa_mem_initiator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/boa_mem_initiator.sv
// boa_mem_initiator: single-outstanding boa_mem_bus master, one bus access per command, registered response stream.
// Optional WAIT timeout recovery is compiled in with BOA_INIT_TIMEOUT_EN.
module boa_mem_initiator #(
`ifdef BOA_INIT_TIMEOUT_EN
    parameter int TIMEOUT   = 255,
`endif
    parameter bit ALIGN_CHK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        bus_re,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        busy_q, busy_d;
    logic        bus_re_q, bus_re_d;
    logic [3:0]  bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
`ifdef BOA_INIT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        bus_re_d    = bus_re_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
`ifdef BOA_INIT_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (ALIGN_CHK && cmd_addr[1:0] != 2'b00) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else begin
                        state_d     = REQ;
                        bus_addr_d  = cmd_addr;
                        bus_wdata_d = cmd_wdata;
                        bus_we_d    = cmd_we;
                        bus_re_d    = (cmd_we == 4'h0);
                    end
                end
            end
            // ready may still be left over from the responder's previous access here, so it is ignored
            REQ: begin
                state_d = WAIT;
`ifdef BOA_INIT_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (bus_ready) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = bus_re_q ? bus_rdata : 32'h0;
                    bus_re_d    = 1'b0;
                    bus_we_d    = 4'h0;
                end
`ifdef BOA_INIT_TIMEOUT_EN
                else if (cnt_q >= CW'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'h0;
                    bus_re_d    = 1'b0;
                    bus_we_d    = 4'h0;
                    cnt_d       = CW'(TIMEOUT);
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
        endcase
        busy_d = (state_d != IDLE);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            bus_re_q    <= 1'b0;
            bus_we_q    <= 4'h0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
`ifdef BOA_INIT_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            bus_re_q    <= bus_re_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
`ifdef BOA_INIT_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end
    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign bus_re    = bus_re_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_boa_mem_initiator.sv
// tb_boa_mem_initiator: directed and random transactions against a wait-state responder and a transaction-level model.
module tb_boa_mem_initiator;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_we = 4'h0;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        bus_re;
    logic [3:0]  bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    int total = 0;
    int bad   = 0;
`ifdef BOA_INIT_TIMEOUT_EN
    localparam int TMO = 8;
`endif

    boa_mem_initiator #(
`ifdef BOA_INIT_TIMEOUT_EN
        .TIMEOUT(TMO),
`endif
        .ALIGN_CHK(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .bus_re(bus_re), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    always #5 clk = ~clk;

    // responder: ready after r_waits low WAIT cycles; r_leak shows a stale ready during REQ
    logic [31:0] r_rdata = 32'h0;
    int          r_waits = 0;
    bit          r_stuck = 1'b0;
    bit          r_leak  = 1'b0;
    int          act     = 0;
    initial begin
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            act       = (bus_re || bus_we != 4'h0) ? act + 1 : 0;
            bus_ready = !r_stuck && act > 0 && (act >= 2 + r_waits || (r_leak && act == 1));
            bus_rdata = r_rdata;
        end
    end

    // monitor: counts access cycles and any bus value or protocol violation
    int          acc_total = 0;
    int          viol      = 0;
    logic [31:0] exp_addr  = 32'h0;
    logic [31:0] exp_wdata = 32'h0;
    logic [3:0]  exp_we    = 4'h0;
    logic [31:0] last_addr = 32'h0;
    always @(negedge clk) begin
        if (rst) begin
            if (bus_re || bus_we != 4'h0) begin
                acc_total = acc_total + 1;
                if (bus_addr !== exp_addr || bus_wdata !== exp_wdata || bus_we !== exp_we || bus_re !== (exp_we == 4'h0))
                    viol = viol + 1;
            end
            if (bus_re && bus_we != 4'h0) viol = viol + 1;
            if (cmd_ready && rsp_valid) viol = viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int waits, input int hold, input bit stuck);
        int          cyc, lat, e_acc, acc0, viol0, stall_bad;
        logic        e_err;
        logic [31:0] e_rd;
        bit          mis;
        mis = (addr[1:0] != 2'b00);
        if (mis) begin
            lat = 0; e_err = 1'b1; e_rd = 32'h0; e_acc = 0;
        end
`ifdef BOA_INIT_TIMEOUT_EN
        else if (stuck) begin
            lat = 1 + TMO; e_err = 1'b1; e_rd = 32'h0; e_acc = 1 + TMO;
        end
`endif
        else begin
            lat = 2 + waits; e_err = 1'b0; e_rd = (we == 4'h0) ? rdata : 32'h0; e_acc = 2 + waits;
        end
        r_rdata = rdata; r_waits = waits; r_stuck = stuck; r_leak = (waits > 0);
        exp_addr = addr; exp_wdata = wdata; exp_we = we;
        acc0 = acc_total; viol0 = viol;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata;
        cyc = 0;
        while (!cmd_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 300) begin @(posedge clk); #1; cyc++; end
        chk("rsp_latency", 32'(cyc), 32'(lat));
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        stall_bad = 0;
        cmd_valid = 1'b1; cmd_we = 4'h0; cmd_addr = {addr[31:2] ^ 30'h1, 2'b00};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (cmd_ready || !rsp_valid || rsp_rdata !== e_rd || rsp_err !== e_err) stall_bad++;
        end
        chk("rsp_stall_stable", 32'(stall_bad), 32'd0);
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
        chk("busy_after_hs", 32'(busy), 32'd0);
        chk("access_cycles", 32'(acc_total - acc0), 32'(e_acc));
        chk("bus_violations", 32'(viol - viol0), 32'd0);
        if (!mis) last_addr = addr;
        chk("bus_addr_held", bus_addr, last_addr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  w;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bus_re_we", {27'h0, bus_re, bus_we}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        do_txn(4'h0, 32'hffff_f008, 32'h0, 32'h1234_5678, 0, 0, 1'b0);
        do_txn(4'hf, 32'hffff_f000, 32'hdead_beef, 32'h5555_aaaa, 4, 0, 1'b0);
        do_txn(4'h0, 32'h0000_0102, 32'h0, 32'h7777_7777, 0, 0, 1'b0);
        do_txn(4'h0, 32'h0000_0200, 32'h0, $urandom, 1, 10, 1'b0);
`ifdef BOA_INIT_TIMEOUT_EN
        do_txn(4'h0, 32'h0000_0300, 32'h0, 32'hcafe_f00d, 0, 0, 1'b1);
        do_txn(4'h0, 32'h0000_0304, 32'h0, 32'h0bad_cafe, 0, 0, 1'b0);
`endif

        r_stuck = 1'b1; r_leak = 1'b0;
        exp_addr = 32'h0000_0400; exp_wdata = 32'h0; exp_we = 4'h0;
        cmd_valid = 1'b1; cmd_we = 4'h0; cmd_addr = 32'h0000_0400; cmd_wdata = 32'h0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_bus_re", 32'(bus_re), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_bus_re_we", {27'h0, bus_re, bus_we}, 32'h0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        r_stuck = 1'b0;
        last_addr = 32'h0;
        @(posedge clk); #1;
        chk("cmd_ready_after_midrst", 32'(cmd_ready), 32'd1);
        do_txn(4'h0, 32'h0000_0500, 32'h0, 32'h1357_9bdf, 2, 1, 1'b0);

        for (int k = 0; k < 20; k++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            w = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            do_txn(w, a, $urandom, $urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
